fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the test CPU.
- Drives the address of the asynchronous instruction ROM (38-bit words: opcode[37:34], s[33:32], a[31:16], b[15:0]) and registers the returned word.
- Hands instructions to decode with a valid/ready handshake and accepts branch redirects from execute.
- Halts at the program end address.

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction-fetch controller. Drives the async ROM address from
//            the PC, registers the returned word toward decode over a
//            valid/ready handshake, takes branch redirects and halts at the
//            program end. Optional macro FETCH_BRANCH_FOLD_EN folds
//            unconditional branches (opcode 4'b0101) inside the fetcher.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12,
  parameter int PROG_LEN   = 169,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  dec_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  deliv_count
);

  localparam logic [ADDR_WIDTH-1:0] c_PROG_END = ADDR_WIDTH'(PROG_LEN);
`ifdef FETCH_BRANCH_FOLD_EN
  localparam logic [3:0]            c_OP_B     = 4'b0101;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_instr, w_instr_nxt;
  logic [ADDR_WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;

  logic w_hs;
  logic w_slot_free;
  logic w_in_prog;

  assign w_hs        = r_valid && dec_ready;
  assign w_slot_free = !r_valid || dec_ready;
  assign w_in_prog   = (r_pc < c_PROG_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_cnt_nxt      = (w_hs && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_FETCH, S_DRAIN: begin
        // Restart outranks redirect; a redirect still lets a same-cycle
        // handshake be counted, a restart clears the count outright.
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (redirect_valid) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = redirect_addr;
          w_valid_nxt = 1'b0;
        end else if (r_state == S_FETCH) begin
          if (w_in_prog) begin
            if (w_slot_free) begin
`ifdef FETCH_BRANCH_FOLD_EN
              if (rom_data[DATA_WIDTH-1 -: 4] == c_OP_B) begin
                w_pc_nxt    = rom_data[ADDR_WIDTH-1:0];
                w_valid_nxt = r_valid && !w_hs;
              end else begin
                w_instr_nxt    = rom_data;
                w_instr_pc_nxt = r_pc;
                w_valid_nxt    = 1'b1;
                w_pc_nxt       = r_pc + 1'b1;
              end
`else
              w_instr_nxt    = rom_data;
              w_instr_pc_nxt = r_pc;
              w_valid_nxt    = 1'b1;
              w_pc_nxt       = r_pc + 1'b1;
`endif
            end
          end else begin
            if (w_hs) begin
              w_valid_nxt = 1'b0;
            end
            w_state_nxt = S_DRAIN;
          end
        end else begin
          if (w_hs) begin
            w_valid_nxt = 1'b0;
          end
          if (!r_valid) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rom_addr    = r_pc;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign halted      = (r_state == S_HALT);
  assign deliv_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed self-checking bench for fetch_sequencer with a
//            combinational ROM model (word 115 is "b 117").
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int DW = 38;
  localparam int AW = 12;
  localparam int CW = 16;

`ifdef FETCH_BRANCH_FOLD_EN
  localparam int FULL_CNT = 167;
  localparam int AFTER_114 = 117;
`else
  localparam int FULL_CNT = 169;
  localparam int AFTER_114 = 115;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          dec_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          busy;
  logic          halted;
  logic [CW-1:0] deliv_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 12'd115) return {4'b0101, 2'b00, 16'h0000, 16'd117};
    return {4'h3, a[1:0], 4'hA, a, 4'h0, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  fetch_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_LEN(169), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .busy(busy), .halted(halted), .deliv_count(deliv_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int pc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (instr_valid && (int'(instr_pc) == pc)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    n_total++; if (rom_addr !== 12'd0) begin n_bad++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
    n_total++; if (instr_out !== '0) begin n_bad++; $display("FAIL reset_instr_out got=%0h want=0", instr_out); end
    n_total++; if (instr_pc !== 12'd0) begin n_bad++; $display("FAIL reset_instr_pc got=%0d want=0", instr_pc); end
    n_total++; if ({busy, halted} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_halted got=%b want=00", {busy, halted}); end
    n_total++; if (deliv_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", deliv_count); end
    tick();
    n_total++; if (busy !== 1'b0 || rom_addr !== 12'd0) begin n_bad++; $display("FAIL idle_no_fetch got busy=%0b addr=%0d want busy=0 addr=0", busy, rom_addr); end
  endtask

  task automatic test_full_run();
    int exp_pc;
    int last_seen;
    int cyc;
    dec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || rom_addr !== 12'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL start_state got busy=%0b addr=%0d valid=%0b want 1/0/0", busy, rom_addr, instr_valid); end
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd0) begin n_bad++; $display("FAIL first_latency got valid=%0b pc=%0d want 1/0", instr_valid, instr_pc); end
    exp_pc = 0;
    last_seen = -100;
    cyc = 0;
    for (int c = 0; c < 400 && !halted; c++) begin
      if (instr_valid) begin
        n_total++; if (int'(instr_pc) != exp_pc || instr_out !== rom_word(AW'(exp_pc))) begin n_bad++; $display("FAIL seq_pc got pc=%0d word=%0h want pc=%0d word=%0h", instr_pc, instr_out, exp_pc, rom_word(AW'(exp_pc))); end
        if (exp_pc == 168) last_seen = cyc;
        exp_pc++;
`ifdef FETCH_BRANCH_FOLD_EN
        if (exp_pc == 115) exp_pc = 117;
`endif
      end
      tick();
      cyc++;
    end
    n_total++; if (halted !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL full_halted got halted=%0b busy=%0b want 1/0", halted, busy); end
    n_total++; if (exp_pc != 169) begin n_bad++; $display("FAIL full_last_pc got next=%0d want 169", exp_pc); end
    n_total++; if (cyc - last_seen != 2) begin n_bad++; $display("FAIL halt_delay got=%0d want=2", cyc - last_seen); end
    n_total++; if (int'(deliv_count) != FULL_CNT) begin n_bad++; $display("FAIL full_count got=%0d want=%0d", deliv_count, FULL_CNT); end
  endtask

  task automatic test_stall();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(10, ok);
    n_total++; if (!ok) begin n_bad++; $display("FAIL stall_reach got=timeout want=pc10"); end
    n_total++; if (deliv_count !== 16'd10) begin n_bad++; $display("FAIL stall_pre_count got=%0d want=10", deliv_count); end
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd10 || rom_addr !== 12'd11 || instr_out !== rom_word(12'd10)) begin
        n_bad++; $display("FAIL stall_hold got valid=%0b pc=%0d addr=%0d want 1/10/11", instr_valid, instr_pc, rom_addr);
      end
    end
    dec_ready = 1'b1;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd11 || deliv_count !== 16'd11) begin n_bad++; $display("FAIL stall_resume got valid=%0b pc=%0d cnt=%0d want 1/11/11", instr_valid, instr_pc, deliv_count); end
  endtask

  task automatic test_redirect();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (deliv_count !== 16'd0 || instr_valid !== 1'b0 || rom_addr !== 12'd0) begin n_bad++; $display("FAIL restart_busy got cnt=%0d valid=%0b addr=%0d want 0/0/0", deliv_count, instr_valid, rom_addr); end
    run_to(108, ok);
    n_total++; if (!ok || deliv_count !== 16'd108) begin n_bad++; $display("FAIL redir_reach got ok=%0b cnt=%0d want 1/108", ok, deliv_count); end
    redirect_valid = 1'b1;
    redirect_addr  = 12'd110;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (instr_valid !== 1'b0 || rom_addr !== 12'd110 || deliv_count !== 16'd109) begin n_bad++; $display("FAIL redir_flush got valid=%0b addr=%0d cnt=%0d want 0/110/109", instr_valid, rom_addr, deliv_count); end
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd110) begin n_bad++; $display("FAIL redir_target got valid=%0b pc=%0d want 1/110", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_halt();
    bit seen_valid;
    redirect_valid = 1'b1;
    redirect_addr  = 12'd200;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (instr_valid !== 1'b0 || rom_addr !== 12'd200 || deliv_count !== 16'd110) begin n_bad++; $display("FAIL far_redir got valid=%0b addr=%0d cnt=%0d want 0/200/110", instr_valid, rom_addr, deliv_count); end
    seen_valid = 1'b0;
    for (int i = 0; i < 4 && !halted; i++) begin
      tick();
      if (instr_valid) seen_valid = 1'b1;
    end
    n_total++; if (halted !== 1'b1 || seen_valid) begin n_bad++; $display("FAIL far_halt got halted=%0b stray=%0b want 1/0", halted, seen_valid); end
    redirect_valid = 1'b1;
    redirect_addr  = 12'd5;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (rom_addr !== 12'd200 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_ignore_redir got addr=%0d halted=%0b want 200/1", rom_addr, halted); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (halted !== 1'b0 || busy !== 1'b1 || rom_addr !== 12'd0 || deliv_count !== 16'd0) begin n_bad++; $display("FAIL halt_restart got halted=%0b busy=%0b addr=%0d cnt=%0d want 0/1/0/0", halted, busy, rom_addr, deliv_count); end
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd0) begin n_bad++; $display("FAIL halt_restart_first got valid=%0b pc=%0d want 1/0", instr_valid, instr_pc); end
  endtask

  task automatic test_branch();
    bit ok;
    int got;
    run_to(114, ok);
    n_total++; if (!ok) begin n_bad++; $display("FAIL br_reach got=timeout want=pc114"); end
    tick();
    got = -1;
    for (int i = 0; i < 5; i++) begin
      if (instr_valid) begin
        got = int'(instr_pc);
        break;
      end
      tick();
    end
    n_total++; if (got != AFTER_114) begin n_bad++; $display("FAIL br_next got=%0d want=%0d", got, AFTER_114); end
  endtask

  task automatic test_async_reset();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(50, ok);
    dec_ready = 1'b0;
    tick();
    tick();
    n_total++; if (!ok || instr_pc !== 12'd50 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL arst_setup got ok=%0b pc=%0d want 1/50", ok, instr_pc); end
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (rom_addr !== 12'd0 || instr_out !== '0 || instr_pc !== 12'd0 || instr_valid !== 1'b0 ||
                  busy !== 1'b0 || halted !== 1'b0 || deliv_count !== 16'd0) begin
      n_bad++; $display("FAIL arst_outputs got addr=%0d pc=%0d valid=%0b busy=%0b cnt=%0d want all 0", rom_addr, instr_pc, instr_valid, busy, deliv_count);
    end
    #3 rst_n = 1'b1;
    dec_ready = 1'b1;
    tick(); tick(); tick();
    n_total++; if (instr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 12'd0) begin n_bad++; $display("FAIL arst_idle got valid=%0b busy=%0b addr=%0d want 0/0/0", instr_valid, busy, rom_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 12'd0) begin n_bad++; $display("FAIL arst_restart got valid=%0b pc=%0d want 1/0", instr_valid, instr_pc); end
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    test_reset();
    test_full_run();
    test_stall();
    test_redirect();
    test_redirect_halt();
    test_branch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
